// File: rtl/tinker_fetch_queue.sv
// Tinker instruction fetch front end: sequential fetch, in-order response queue, redirect flush.
// Optional macro HALT_STOP_EN: stop issuing fetches once a halt word has been enqueued.
module tinker_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h2000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   output logic        halted
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int DW = CW + 4;

   logic [63:0]   r_fetch_pc;
   logic [PW-1:0] r_q_wr;
   logic [PW-1:0] r_q_rd;
   logic [CW-1:0] r_q_cnt;
   logic [PW-1:0] r_t_wr;
   logic [PW-1:0] r_t_rd;
   logic [CW-1:0] r_inflight;
   logic [DW-1:0] r_discard;

   logic [63:0]   r_q_pc    [DEPTH];
   logic [31:0]   r_q_instr [DEPTH];
   logic [63:0]   r_t_pc    [DEPTH];

   logic          w_run;
   logic          w_credit;
   logic          w_req_valid;
   logic          w_accept;
   logic          w_drop;
   logic          w_push;
   logic          w_not_empty;
   logic          w_pop;

   // Credit counts both queued words and outstanding requests so a push can never find the queue full.
   assign w_credit    = ({1'b0, r_q_cnt} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
   assign w_req_valid = reset & w_run & ~redirect_valid & w_credit;
   assign w_accept    = w_req_valid & imem_req_ready;
   assign w_drop      = imem_resp_valid & (r_discard != '0);
   assign w_push      = imem_resp_valid & ~w_drop & ~redirect_valid;
   assign w_not_empty = (r_q_cnt != '0);
   assign w_pop       = w_not_empty & out_ready;

`ifdef HALT_STOP_EN
   typedef enum logic {S_RUN, S_HALT} state_t;
   state_t r_state;
   state_t w_state_nxt;
   logic   w_halt_word;

   assign w_halt_word = w_push & (imem_resp_data[31:27] == 5'h0f) & (imem_resp_data[3:0] == 4'h0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid)                       w_state_nxt = S_RUN;
      else if (r_state == S_RUN && w_halt_word) w_state_nxt = S_HALT;
   end

   assign w_run  = (r_state == S_RUN);
   assign halted = reset & (r_state == S_HALT);
`else
   assign w_run  = 1'b1;
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_q_wr     <= '0;
         r_q_rd     <= '0;
         r_q_cnt    <= '0;
         r_t_wr     <= '0;
         r_t_rd     <= '0;
         r_inflight <= '0;
         r_discard  <= '0;
      end else if (redirect_valid) begin
         // A response landing this cycle is already counted in r_inflight and is dropped here.
         r_fetch_pc <= redirect_pc & ~64'h3;
         r_q_wr     <= '0;
         r_q_rd     <= '0;
         r_q_cnt    <= '0;
         r_t_wr     <= '0;
         r_t_rd     <= '0;
         r_inflight <= '0;
         r_discard  <= r_discard + DW'(r_inflight) - DW'(imem_resp_valid);
      end else begin
         if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 64'd4;
            r_t_wr     <= r_t_wr + 1'b1;
         end
         if (w_push) begin
            r_q_wr <= r_q_wr + 1'b1;
            r_t_rd <= r_t_rd + 1'b1;
         end
         if (w_pop) r_q_rd <= r_q_rd + 1'b1;
         r_q_cnt    <= r_q_cnt + CW'(w_push) - CW'(w_pop);
         r_inflight <= r_inflight + CW'(w_accept) - CW'(w_push);
         r_discard  <= r_discard - DW'(w_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_t_pc[r_t_wr] <= r_fetch_pc;
      if (w_push) begin
         r_q_pc[r_q_wr]    <= r_t_pc[r_t_rd];
         r_q_instr[r_q_wr] <= imem_resp_data;
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = reset ? r_fetch_pc : 64'd0;
   assign out_valid      = reset & w_not_empty;
   assign out_pc         = out_valid ? r_q_pc[r_q_rd] : 64'd0;
   assign out_instr      = out_valid ? r_q_instr[r_q_rd] : 32'd0;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Directed bench for tinker_fetch_queue with an in-order instruction memory model.
module tb_tinker_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        halted;

   int passed = 0;
   int total  = 0;

   logic [63:0] pend[$];
   logic [63:0] issued[$];
   logic [63:0] consumed[$];
   logic [31:0] consumed_instr[$];
   bit          mem_hold = 0;
   logic [63:0] halt_addr = 64'hFFFF_FFFF_FFFF_FFF0;

   logic        s_req_valid, s_out_valid, s_halted;
   logic [63:0] s_req_addr, s_out_pc;

   tinker_fetch_queue #(.DEPTH(4), .RESET_PC(64'h2000)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
      .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == halt_addr) return 32'h7800_0000;
      return {8'h13, a[23:0]};
   endfunction

   // One clock: drive memory response, sample at negedge, update model at posedge.
   task automatic tick();
      bit          acc, rsp, pop;
      logic [63:0] aa, pp;
      logic [31:0] ii;
      imem_resp_valid = !mem_hold && (pend.size() > 0);
      imem_resp_data  = imem_resp_valid ? mem_word(pend[0]) : 32'd0;
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      aa  = imem_req_addr;
      rsp = imem_resp_valid;
      pop = out_valid && out_ready;
      pp  = out_pc;
      ii  = out_instr;
      s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
      s_out_valid = out_valid; s_out_pc = out_pc; s_halted = halted;
      @(posedge clk);
      if (rsp && pend.size() > 0) void'(pend.pop_front());
      if (acc) begin pend.push_back(aa); issued.push_back(aa); end
      if (pop) begin consumed.push_back(pp); consumed_instr.push_back(ii); end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      pend.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      issued.delete(); consumed.delete(); consumed_instr.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); else passed++;
      total++; if (imem_req_addr !== 64'd0) $display("FAIL rst_req_addr: got %h expected 0", imem_req_addr); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
      total++; if (out_pc !== 64'd0 || out_instr !== 32'd0) $display("FAIL rst_out_data: got %h/%h expected 0/0", out_pc, out_instr); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b expected 0", halted); else passed++;
   endtask

   task automatic test_sequential();
      int bad;
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1;
      repeat (12) tick();
      total++; if (issued[0] !== 64'h2000) $display("FAIL seq_req0: got %h expected 2000", issued[0]); else passed++;
      total++; if (issued[1] !== 64'h2004) $display("FAIL seq_req1: got %h expected 2004", issued[1]); else passed++;
      total++; if (issued[2] !== 64'h2008) $display("FAIL seq_req2: got %h expected 2008", issued[2]); else passed++;
      total++; if (consumed.size() < 8) $display("FAIL seq_count: got %0d expected >=8", consumed.size()); else passed++;
      bad = -1;
      foreach (consumed[i])
         if (bad < 0 && (consumed[i] !== 64'h2000 + 64'(i) * 4 || consumed_instr[i] !== mem_word(consumed[i]))) bad = i;
      total++;
      if (bad >= 0) $display("FAIL seq_order: got pc %h instr %h at %0d expected pc %h", consumed[bad], consumed_instr[bad], bad, 64'h2000 + 64'(bad) * 4);
      else passed++;
   endtask

   task automatic test_backpressure();
      int bad;
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b0;
      repeat (10) tick();
      total++; if (issued.size() != 4) $display("FAIL bp_issued: got %0d expected 4", issued.size()); else passed++;
      total++; if (s_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b expected 0", s_req_valid); else passed++;
      total++; if (s_out_valid !== 1'b1 || s_out_pc !== 64'h2000) $display("FAIL bp_head: got %b/%h expected 1/2000", s_out_valid, s_out_pc); else passed++;
      out_ready = 1'b1;
      repeat (20) tick();
      total++; if (consumed.size() < 12) $display("FAIL bp_resume_count: got %0d expected >=12", consumed.size()); else passed++;
      bad = -1;
      foreach (consumed[i])
         if (bad < 0 && (consumed[i] !== 64'h2000 + 64'(i) * 4 || consumed_instr[i] !== mem_word(consumed[i]))) bad = i;
      total++;
      if (bad >= 0) $display("FAIL bp_resume_order: got %h at %0d expected %h", consumed[bad], bad, 64'h2000 + 64'(bad) * 4);
      else passed++;
   endtask

   task automatic test_redirect();
      int bad;
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1; mem_hold = 1;
      repeat (2) tick();
      total++; if (pend.size() != 2) $display("FAIL rd_inflight: got %0d expected 2", pend.size()); else passed++;
      issued.delete();
      redirect_valid = 1'b1; redirect_pc = 64'h3003;
      tick();
      redirect_valid = 1'b0; mem_hold = 0;
      total++; if (s_req_valid !== 1'b0) $display("FAIL rd_req_in_redirect: got %b expected 0", s_req_valid); else passed++;
      repeat (15) tick();
      total++; if (issued[0] !== 64'h3000) $display("FAIL rd_next_req: got %h expected 3000", issued[0]); else passed++;
      total++; if (consumed[0] !== 64'h3000) $display("FAIL rd_first_out_pc: got %h expected 3000", consumed[0]); else passed++;
      total++; if (consumed_instr[0] !== mem_word(64'h3000)) $display("FAIL rd_first_instr: got %h expected %h", consumed_instr[0], mem_word(64'h3000)); else passed++;
      bad = -1;
      foreach (consumed[i])
         if (bad < 0 && (consumed[i] !== 64'h3000 + 64'(i) * 4 || consumed_instr[i] !== mem_word(consumed[i]))) bad = i;
      total++;
      if (bad >= 0) $display("FAIL rd_stream: got %h at %0d expected %h", consumed[bad], bad, 64'h3000 + 64'(bad) * 4);
      else passed++;
   endtask

   task automatic test_redirect_collide();
      int n2000;
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b0;
      repeat (4) tick();
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h4000;
      tick();
      redirect_valid = 1'b0;
      tick();
      total++; if (s_out_valid !== 1'b0) $display("FAIL col_out_valid_after: got %b expected 0", s_out_valid); else passed++;
      repeat (10) tick();
      n2000 = 0;
      foreach (consumed[i]) if (consumed[i] == 64'h2000) n2000++;
      total++; if (n2000 != 1 || consumed[0] !== 64'h2000) $display("FAIL col_head_once: got %0d copies, first %h expected 1, 2000", n2000, consumed[0]); else passed++;
      total++; if (consumed[1] !== 64'h4000 || consumed_instr[1] !== mem_word(64'h4000)) $display("FAIL col_next: got %h/%h expected 4000/%h", consumed[1], consumed_instr[1], mem_word(64'h4000)); else passed++;
   endtask

   task automatic test_halt();
      halt_addr = 64'h2008;
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b1;
      repeat (15) tick();
      total++; if (consumed[2] !== 64'h2008 || consumed_instr[2] !== 32'h7800_0000) $display("FAIL halt_word_out: got %h/%h expected 2008/78000000", consumed[2], consumed_instr[2]); else passed++;
`ifdef HALT_STOP_EN
      total++; if (s_halted !== 1'b1) $display("FAIL halt_flag: got %b expected 1", s_halted); else passed++;
      total++; if (issued.size() != 4 || issued[3] !== 64'h200c) $display("FAIL halt_no_issue: got %0d reqs, last %h expected 4, 200c", issued.size(), issued[issued.size()-1]); else passed++;
      total++; if (s_req_valid !== 1'b0) $display("FAIL halt_req_valid: got %b expected 0", s_req_valid); else passed++;
      redirect_valid = 1'b1; redirect_pc = 64'h5000;
      tick();
      redirect_valid = 1'b0;
      tick();
      total++; if (s_halted !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 64'h5000) $display("FAIL halt_resume: got %b/%b/%h expected 0/1/5000", s_halted, s_req_valid, s_req_addr); else passed++;
`else
      total++; if (s_halted !== 1'b0) $display("FAIL nohalt_flag: got %b expected 0", s_halted); else passed++;
      total++; if (issued.size() < 10) $display("FAIL nohalt_issue: got %0d expected >=10", issued.size()); else passed++;
      total++; if (consumed[3] !== 64'h200c) $display("FAIL nohalt_next: got %h expected 200c", consumed[3]); else passed++;
`endif
      halt_addr = 64'hFFFF_FFFF_FFFF_FFF0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem_req_ready = 1'b1; out_ready = 1'b0;
      repeat (2) tick();
      mem_hold = 1;
      repeat (3) tick();
      total++; if (pend.size() != 3 || s_out_valid !== 1'b1) $display("FAIL mid_setup: got %0d inflight, valid %b expected 3, 1", pend.size(), s_out_valid); else passed++;
      #2;
      reset = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_pc !== 64'd0 || out_instr !== 32'd0) $display("FAIL mid_out_zero: got %b/%h/%h expected 0/0/0", out_valid, out_pc, out_instr); else passed++;
      total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'd0) $display("FAIL mid_req_zero: got %b/%h expected 0/0", imem_req_valid, imem_req_addr); else passed++;
      pend.delete(); mem_hold = 0; imem_resp_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      issued.delete(); consumed.delete(); consumed_instr.delete();
      out_ready = 1'b1;
      repeat (6) tick();
      total++; if (issued[0] !== 64'h2000) $display("FAIL mid_first_req: got %h expected 2000", issued[0]); else passed++;
      total++; if (consumed[0] !== 64'h2000) $display("FAIL mid_first_out: got %h expected 2000", consumed[0]); else passed++;
   endtask

   initial begin
      reset = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
